round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
Game-round controller for the roulette datapath. It collects the wager and the picked numbers from debounced button pulses. It then sequences spin → hit check → balance update, and issues the single-cycle update request to the balance manager. It watches the balance flags to end the game (bankrupt / 10000 reached). It sits between the button/input layer and the spin, hit-check and balance blocks, and drives the display state code.

Parameters:
MONEY_W, 16, width of balance and bet amount
BET_STEP, 10, increment/decrement per bet_up/bet_down pulse
MAX_PICKS, 4, maximum numbers per round (bet_count range 1..MAX_PICKS)
MAX_NUM, 36, highest legal roulette number (0..MAX_NUM)
SPIN_TIMEOUT, 50000000, cycles allowed for spin_done before abort
RESULT_HOLD, 100000000, cycles the RESULT state is shown before auto-advance

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
bet_up  in  1  one-cycle pulse: bet += BET_STEP
bet_down  in  1  one-cycle pulse: bet -= BET_STEP
pick_valid  in  1  one-cycle pulse: pick_num is a new pick
pick_num  in  6  picked number
confirm  in  1  one-cycle pulse: advance / skip result
cancel  in  1  one-cycle pulse: clear picks, return to BET
spin_done  in  1  spin block finished (level or pulse; first high cycle counts)
hit_valid  in  1  hit check result valid (one cycle)
hit_win  in  1  hit check win/lose, sampled with hit_valid
hit_cnt_in  in  3  hit count, sampled with hit_valid
current_money  in  MONEY_W  balance from balance manager
money_zero  in  1  balance == 0
money_10000  in  1  balance >= 10000
bet_amount  out  MONEY_W  current wager
bet_count  out  3  number of picks (0..4)
pick_list  out  24  4 × 6-bit picks, slot0 in [5:0]; unused slots = 0
spin_start  out  1  one-cycle pulse to spin block
check_req  out  1  one-cycle pulse to hit check
update_req  out  1  one-cycle balance update request
win_flag  out  1  latched hit_win of last round
hit_count  out  3  latched hit_cnt_in of last round
state_code  out  4  encoded FSM state for display
bet_err  out  1  high for 1 cycle on rejected confirm/timeout
game_over  out  1  sticky until rst
game_clear  out  1  sticky until rst

Behaviour:
- Reset (async, immediate):
  - state = IDLE; bet_amount = BET_STEP; bet_count = 0; pick_list = 0.
  - All pulses = 0; win_flag = 0; hit_count = 0; game_over = 0; game_clear = 0; timers = 0.
  - Reset mid-round aborts with no update_req issued.
- States and state_code: IDLE=0, BET=1, PICK=2, SPIN=3, CHECK=4, UPDATE=5, SETTLE=6, RESULT=7, OVER=8, CLEAR=9.
- IDLE: confirm → BET.
- BET:
  - bet_up adds BET_STEP, saturating at current_money.
  - bet_down subtracts BET_STEP, saturating at 0.
  - bet_up and bet_down in the same cycle → no change.
  - confirm with 0 < bet_amount <= current_money → PICK; otherwise bet_err, stay.
- PICK:
  - pick_valid with pick_num <= MAX_NUM, not already listed, and bet_count < MAX_PICKS → stored in slot bet_count, bet_count++.
  - Otherwise the pick is ignored silently.
  - cancel → clear picks, go to BET.
  - confirm with bet_count >= 1 → SPIN, emitting spin_start on the transition cycle; with bet_count = 0 → bet_err, stay.
- SPIN:
  - Timer counts cycles.
  - spin_done → CHECK with check_req pulse.
  - Timer reaching SPIN_TIMEOUT first → bet_err, BET, picks cleared, no update.
- CHECK: wait for hit_valid. Latch win_flag and hit_count, then → UPDATE. No timeout.
- UPDATE:
  - update_req = 1 for exactly one cycle, then → SETTLE.
  - bet_amount, bet_count and pick_list must be stable from the PICK confirm until SETTLE exits.
- SETTLE: wait exactly 2 cycles (balance registers, then flags registers), then evaluate:
  - money_zero → OVER.
  - else money_10000 → CLEAR.
  - else → RESULT.
- RESULT: hold RESULT_HOLD cycles or until confirm, then → BET.
  - Picks cleared.
  - bet_amount clamped to min(bet_amount, current_money); if that gives 0, set it to min(BET_STEP, current_money).
- OVER / CLEAR: terminal; set game_over / game_clear; all inputs ignored until rst.
- Inputs not listed for a state are ignored in it.
- confirm and cancel in the same cycle → cancel wins.
- All outputs are registered; pulses never last longer than 1 cycle.

Decomposition:
- Package roulette_pkg holds:
  - state enum / state_code constants;
  - MAX_NUM, MAX_PICKS, MONEY_W;
  - pick_list slot width (6) and packing macros.
- One sub-module, pick_collector: duplicate/range/count checking and pick_list storage, with clear and add ports. The main FSM stays in round_sequencer.

Test Plan:
- Bet bounds: rst, balance 100; bet_up ×12 → bet_amount 100 (saturated); bet_down ×11 → 0; confirm → bet_err pulse, state_code stays 1.
- Picks: picks 7, 7, 40, 0, 36, 12, 5 → bet_count 4, pick_list slots = 7, 0, 36, 12; the duplicate 7, the out-of-range 40 and the fifth pick 5 are ignored.
- Normal round, bet 50, balance 100:
  - spin_done after 10 cycles, then hit_valid with win = 1, count = 1.
  - Expect spin_start, check_req and update_req each exactly 1 cycle, in that order.
  - SETTLE lasts 2 cycles; state_code 7; win_flag = 1.
- Loss to zero: bet 100, balance 100, hit_win = 0, balance manager reports money_zero two cycles after update_req → state_code 8, game_over = 1; further confirm pulses cause no change.
- Timeout: SPIN_TIMEOUT = 20, no spin_done → after 20 cycles bet_err, state_code 1, bet_count 0, no update_req seen.
- Async reset asserted in UPDATE mid-cycle → outputs return to reset values immediately; update_req never seen high after reset.

Source files
------------

// File: rtl/roulette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roulette_pkg
// Description : Shared types and constants for the roulette round controller.
// Revision    : 1.0 - initial release
// ============================================================================
package roulette_pkg;

    localparam int MONEY_W     = 16;
    localparam int MAX_PICKS   = 4;
    localparam int MAX_NUM     = 36;
    localparam int SLOT_W      = 6;
    localparam int CNT_W       = 3;
    localparam int PICK_LIST_W = MAX_PICKS * SLOT_W;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_BET    = 4'd1,
        ST_PICK   = 4'd2,
        ST_SPIN   = 4'd3,
        ST_CHECK  = 4'd4,
        ST_UPDATE = 4'd5,
        ST_SETTLE = 4'd6,
        ST_RESULT = 4'd7,
        ST_OVER   = 4'd8,
        ST_CLEAR  = 4'd9
    } state_t;

    // Slot 0 lives in the least significant bits of the packed pick list.
    function automatic logic [SLOT_W-1:0] slot_get(input logic [PICK_LIST_W-1:0] list,
                                                   input int idx);
        return list[idx*SLOT_W +: SLOT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer_if
// Description : Bundle of button, datapath-handshake and status signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface round_sequencer_if;
    import roulette_pkg::*;

    logic                   bet_up;
    logic                   bet_down;
    logic                   pick_valid;
    logic [SLOT_W-1:0]      pick_num;
    logic                   confirm;
    logic                   cancel;
    logic                   spin_done;
    logic                   hit_valid;
    logic                   hit_win;
    logic [CNT_W-1:0]       hit_cnt_in;
    logic [MONEY_W-1:0]     current_money;
    logic                   money_zero;
    logic                   money_10000;
    logic [MONEY_W-1:0]     bet_amount;
    logic [CNT_W-1:0]       bet_count;
    logic [PICK_LIST_W-1:0] pick_list;
    logic                   spin_start;
    logic                   check_req;
    logic                   update_req;
    logic                   win_flag;
    logic [CNT_W-1:0]       hit_count;
    logic [3:0]             state_code;
    logic                   bet_err;
    logic                   game_over;
    logic                   game_clear;

    modport master (
        input  bet_up, bet_down, pick_valid, pick_num, confirm, cancel, spin_done,
               hit_valid, hit_win, hit_cnt_in, current_money, money_zero, money_10000,
        output bet_amount, bet_count, pick_list, spin_start, check_req, update_req,
               win_flag, hit_count, state_code, bet_err, game_over, game_clear
    );

    modport slave (
        output bet_up, bet_down, pick_valid, pick_num, confirm, cancel, spin_done,
               hit_valid, hit_win, hit_cnt_in, current_money, money_zero, money_10000,
        input  bet_amount, bet_count, pick_list, spin_start, check_req, update_req,
               win_flag, hit_count, state_code, bet_err, game_over, game_clear
    );

endinterface
`default_nettype wire

// File: rtl/round_sequencer_pick_collector.sv
`default_nettype none
// ============================================================================
// Module      : pick_collector
// Description : Stores up to MAX_PICKS distinct in-range picks, packed by slot.
// Revision    : 1.0 - initial release
// ============================================================================
module pick_collector
    import roulette_pkg::*;
#(
    parameter int MAX_NUM_P = roulette_pkg::MAX_NUM
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_clear,
    input  wire logic                   i_add,
    input  wire logic [SLOT_W-1:0]      i_num,
    output logic      [PICK_LIST_W-1:0] o_pick_list,
    output logic      [CNT_W-1:0]       o_count
);

    logic [PICK_LIST_W-1:0] r_list;
    logic [CNT_W-1:0]       r_count;
    logic [MAX_PICKS-1:0]   w_dup;
    logic [PICK_LIST_W-1:0] w_list_next;
    logic                   w_accept;

    generate
        for (genvar i = 0; i < MAX_PICKS; i++) begin : g_slot
            assign w_dup[i] = (CNT_W'(i) < r_count) && (slot_get(r_list, i) == i_num);
        end
    endgenerate

    assign w_accept = i_add && (i_num <= SLOT_W'(MAX_NUM_P)) &&
                      (r_count < CNT_W'(MAX_PICKS)) && !(|w_dup);

    always_comb begin
        w_list_next = r_list;
        for (int i = 0; i < MAX_PICKS; i++) begin
            if (r_count == CNT_W'(i)) begin
                w_list_next[i*SLOT_W +: SLOT_W] = i_num;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_list  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_list  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_list  <= w_list_next;
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_pick_list = r_list;
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Roulette round FSM: wager, picks, spin, hit check, settle.
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer
    import roulette_pkg::*;
#(
    parameter int BET_STEP     = 10,
    parameter int SPIN_TIMEOUT = 50000000,
    parameter int RESULT_HOLD  = 100000000,
    parameter int MAX_NUM_P    = roulette_pkg::MAX_NUM
) (
    input  wire logic         clk,
    input  wire logic         rst,
    round_sequencer_if.master bus
);

    localparam logic [MONEY_W-1:0] c_STEP      = MONEY_W'(BET_STEP);
    localparam logic [31:0]        c_SPIN_LAST = 32'(SPIN_TIMEOUT - 1);
    localparam logic [31:0]        c_HOLD_LAST = 32'(RESULT_HOLD - 1);

    state_t             r_state;
    logic [MONEY_W-1:0] r_bet;
    logic [31:0]        r_timer;
    logic               r_spin_start, r_check_req, r_update_req, r_bet_err;
    logic               r_win, r_over, r_clear;
    logic [CNT_W-1:0]   r_hit_cnt;

    logic [CNT_W-1:0]       w_count;
    logic [PICK_LIST_W-1:0] w_list;
    logic                   w_confirm, w_spin_timeout, w_result_exit;
    logic                   w_pick_clear, w_pick_add, w_bet_ok;
    logic [MONEY_W:0]       w_up_sum;
    logic [MONEY_W-1:0]     w_bet_inc, w_bet_dec, w_bet_min, w_step_min, w_bet_clamp;

    // A simultaneous cancel always overrides confirm.
    assign w_confirm      = bus.confirm & ~bus.cancel;
    assign w_spin_timeout = (r_state == ST_SPIN) & ~bus.spin_done & (r_timer == c_SPIN_LAST);
    assign w_result_exit  = (r_state == ST_RESULT) & (w_confirm | (r_timer == c_HOLD_LAST));
    assign w_pick_clear   = ((r_state == ST_PICK) & bus.cancel) | w_spin_timeout | w_result_exit;
    assign w_pick_add     = (r_state == ST_PICK) & bus.pick_valid & ~bus.confirm & ~bus.cancel;

    assign w_up_sum    = {1'b0, r_bet} + {1'b0, c_STEP};
    assign w_bet_inc   = (w_up_sum > {1'b0, bus.current_money}) ? bus.current_money
                                                                : w_up_sum[MONEY_W-1:0];
    assign w_bet_dec   = (r_bet < c_STEP) ? '0 : (r_bet - c_STEP);
    assign w_bet_ok    = (r_bet != '0) && (r_bet <= bus.current_money);
    assign w_bet_min   = (r_bet > bus.current_money) ? bus.current_money : r_bet;
    assign w_step_min  = (bus.current_money < c_STEP) ? bus.current_money : c_STEP;
    assign w_bet_clamp = (w_bet_min == '0) ? w_step_min : w_bet_min;

    pick_collector #(
        .MAX_NUM_P (MAX_NUM_P)
    ) u_pick_collector (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_pick_clear),
        .i_add       (w_pick_add),
        .i_num       (bus.pick_num),
        .o_pick_list (w_list),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bet        <= c_STEP;
            r_timer      <= '0;
            r_spin_start <= 1'b0;
            r_check_req  <= 1'b0;
            r_update_req <= 1'b0;
            r_bet_err    <= 1'b0;
            r_win        <= 1'b0;
            r_hit_cnt    <= '0;
            r_over       <= 1'b0;
            r_clear      <= 1'b0;
        end else begin
            r_spin_start <= 1'b0;
            r_check_req  <= 1'b0;
            r_update_req <= 1'b0;
            r_bet_err    <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_confirm) r_state <= ST_BET;
                ST_BET: begin
                    if (w_confirm) begin
                        if (w_bet_ok) r_state   <= ST_PICK;
                        else          r_bet_err <= 1'b1;
                    end else if (bus.bet_up && !bus.bet_down) begin
                        r_bet <= w_bet_inc;
                    end else if (bus.bet_down && !bus.bet_up) begin
                        r_bet <= w_bet_dec;
                    end
                end
                ST_PICK: begin
                    if (bus.cancel) begin
                        r_state <= ST_BET;
                    end else if (bus.confirm) begin
                        if (w_count != '0) begin
                            r_state      <= ST_SPIN;
                            r_spin_start <= 1'b1;
                            r_timer      <= '0;
                        end else begin
                            r_bet_err <= 1'b1;
                        end
                    end
                end
                ST_SPIN: begin
                    if (bus.spin_done) begin
                        r_state     <= ST_CHECK;
                        r_check_req <= 1'b1;
                    end else if (w_spin_timeout) begin
                        r_state   <= ST_BET;
                        r_bet_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_CHECK: if (bus.hit_valid) begin
                    r_win        <= bus.hit_win;
                    r_hit_cnt    <= bus.hit_cnt_in;
                    r_update_req <= 1'b1;
                    r_state      <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_state <= ST_SETTLE;
                    r_timer <= '0;
                end
                // Second SETTLE cycle sees the flags registered after the balance update.
                ST_SETTLE: begin
                    if (r_timer == 32'd1) begin
                        r_timer <= '0;
                        if (bus.money_zero) begin
                            r_state <= ST_OVER;
                            r_over  <= 1'b1;
                        end else if (bus.money_10000) begin
                            r_state <= ST_CLEAR;
                            r_clear <= 1'b1;
                        end else begin
                            r_state <= ST_RESULT;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_RESULT: begin
                    if (w_result_exit) begin
                        r_state <= ST_BET;
                        r_bet   <= w_bet_clamp;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_OVER, ST_CLEAR: r_state <= r_state;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bet_amount = r_bet;
    assign bus.bet_count  = w_count;
    assign bus.pick_list  = w_list;
    assign bus.spin_start = r_spin_start;
    assign bus.check_req  = r_check_req;
    assign bus.update_req = r_update_req;
    assign bus.win_flag   = r_win;
    assign bus.hit_count  = r_hit_cnt;
    assign bus.state_code = r_state;
    assign bus.bet_err    = r_bet_err;
    assign bus.game_over  = r_over;
    assign bus.game_clear = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_sequencer
// Description : Directed self-checking bench for round_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   upd_seen = 0;
    int   snap;

    always #5 clk = ~clk;

    round_sequencer_if bus ();

    round_sequencer #(
        .BET_STEP     (10),
        .SPIN_TIMEOUT (20),
        .RESULT_HOLD  (30),
        .MAX_NUM_P    (36)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.update_req === 1'b1) upd_seen <= upd_seen + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_confirm();
        bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    endtask

    task automatic bet_up_n(input int n);
        repeat (n) begin bus.bet_up = 1'b1; tick(); bus.bet_up = 1'b0; end
    endtask

    task automatic bet_down_n(input int n);
        repeat (n) begin bus.bet_down = 1'b1; tick(); bus.bet_down = 1'b0; end
    endtask

    task automatic pick(input logic [5:0] n);
        bus.pick_valid = 1'b1; bus.pick_num = n; tick(); bus.pick_valid = 1'b0;
    endtask

    // From PICK with picks: run spin, hit check and settle, ending in exp_state.
    task automatic spin_round(input int wait_n, input logic win, input logic [2:0] cnt,
                              input logic [15:0] bet_exp, input logic [15:0] money_after,
                              input logic zero, input logic big, input logic [3:0] exp_state);
        do_confirm();
        chk("spin_start", bus.spin_start, 1);
        chk("st_spin", bus.state_code, 3);
        repeat (wait_n) tick();
        bus.spin_done = 1'b1; tick(); bus.spin_done = 1'b0;
        chk("st_check", bus.state_code, 4);
        chk("check_req", bus.check_req, 1);
        chk("spin_start_low", bus.spin_start, 0);
        bus.hit_valid = 1'b1; bus.hit_win = win; bus.hit_cnt_in = cnt;
        tick();
        bus.hit_valid = 1'b0;
        chk("st_update", bus.state_code, 5);
        chk("update_req", bus.update_req, 1);
        chk("check_req_low", bus.check_req, 0);
        chk("win_flag", bus.win_flag, 32'(win));
        chk("hit_count", bus.hit_count, 32'(cnt));
        chk("bet_stable", bus.bet_amount, 32'(bet_exp));
        tick();
        bus.current_money = money_after;
        chk("st_settle1", bus.state_code, 6);
        chk("update_req_low", bus.update_req, 0);
        tick();
        bus.money_zero = zero; bus.money_10000 = big;
        chk("st_settle2", bus.state_code, 6);
        tick();
        chk("st_after_settle", bus.state_code, 32'(exp_state));
    endtask

    initial begin
        bus.bet_up = 0; bus.bet_down = 0; bus.pick_valid = 0; bus.pick_num = 0;
        bus.confirm = 0; bus.cancel = 0; bus.spin_done = 0; bus.hit_valid = 0;
        bus.hit_win = 0; bus.hit_cnt_in = 0; bus.current_money = 16'd100;
        bus.money_zero = 0; bus.money_10000 = 0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_state", bus.state_code, 0);
        chk("rst_bet", bus.bet_amount, 10);
        chk("rst_count", bus.bet_count, 0);
        chk("rst_list", bus.pick_list, 0);
        chk("rst_over", bus.game_over, 0);
        chk("rst_clear", bus.game_clear, 0);

        do_confirm();
        chk("idle_to_bet", bus.state_code, 1);

        bet_up_n(12);
        chk("bet_sat_hi", bus.bet_amount, 100);
        bet_down_n(11);
        chk("bet_sat_lo", bus.bet_amount, 0);
        bus.bet_up = 1; bus.bet_down = 1; tick(); bus.bet_up = 0; bus.bet_down = 0;
        chk("bet_updown", bus.bet_amount, 0);
        do_confirm();
        chk("bet0_err", bus.bet_err, 1);
        chk("bet0_stay", bus.state_code, 1);
        tick();
        chk("bet_err_pulse", bus.bet_err, 0);

        bet_up_n(5);
        chk("bet_50", bus.bet_amount, 50);
        do_confirm();
        chk("to_pick", bus.state_code, 2);
        do_confirm();
        chk("pick0_err", bus.bet_err, 1);
        chk("pick0_stay", bus.state_code, 2);
        pick(6'd3);
        chk("pick_one", bus.bet_count, 1);
        bus.cancel = 1; bus.confirm = 1; tick(); bus.cancel = 0; bus.confirm = 0;
        chk("cancel_wins", bus.state_code, 1);
        chk("cancel_clr", bus.bet_count, 0);
        chk("cancel_nospin", bus.spin_start, 0);
        do_confirm();
        chk("repick", bus.state_code, 2);

        pick(6'd7); pick(6'd7);
        chk("dup_ignored", bus.bet_count, 1);
        pick(6'd40); pick(6'd0); pick(6'd36); pick(6'd12); pick(6'd5);
        chk("pick_count", bus.bet_count, 4);
        chk("pick_list", bus.pick_list, 32'({6'd12, 6'd36, 6'd0, 6'd7}));

        spin_round(9, 1'b1, 3'd1, 16'd50, 16'd150, 1'b0, 1'b0, 4'd7);
        chk("res_win", bus.win_flag, 1);
        chk("res_list_held", bus.pick_list, 32'({6'd12, 6'd36, 6'd0, 6'd7}));
        do_confirm();
        chk("res_to_bet", bus.state_code, 1);
        chk("res_clr_cnt", bus.bet_count, 0);
        chk("res_clr_list", bus.pick_list, 0);
        chk("res_bet_kept", bus.bet_amount, 50);

        do_confirm();
        pick(6'd1);
        spin_round(0, 1'b0, 3'd0, 16'd50, 16'd30, 1'b0, 1'b0, 4'd7);
        chk("res_lose", bus.win_flag, 0);
        repeat (29) tick();
        chk("hold_stay", bus.state_code, 7);
        tick();
        chk("hold_exit", bus.state_code, 1);
        chk("bet_clamped", bus.bet_amount, 30);

        bus.current_money = 16'd100;
        bet_up_n(7);
        chk("bet_100", bus.bet_amount, 100);
        do_confirm();
        pick(6'd5);
        spin_round(3, 1'b0, 3'd0, 16'd100, 16'd0, 1'b1, 1'b0, 4'd8);
        chk("game_over", bus.game_over, 1);
        do_confirm(); do_confirm();
        chk("over_stuck", bus.state_code, 8);
        chk("over_noerr", bus.bet_err, 0);

        rst = 1'b1; tick(); rst = 1'b0;
        bus.money_zero = 0; bus.current_money = 16'd100;
        chk("rst2_state", bus.state_code, 0);
        chk("rst2_over", bus.game_over, 0);
        do_confirm(); do_confirm();
        pick(6'd9);
        snap = upd_seen;
        do_confirm();
        chk("to_spin_to", bus.state_code, 3);
        repeat (19) tick();
        chk("spin_wait", bus.state_code, 3);
        tick();
        chk("timeout_err", bus.bet_err, 1);
        chk("timeout_bet", bus.state_code, 1);
        chk("timeout_clr", bus.bet_count, 0);
        chk("timeout_noupd", upd_seen, snap);

        do_confirm();
        pick(6'd9);
        do_confirm();
        bus.spin_done = 1; tick(); bus.spin_done = 0;
        bus.hit_valid = 1; bus.hit_win = 1; bus.hit_cnt_in = 3'd2; tick(); bus.hit_valid = 0;
        chk("pre_rst_upd", bus.state_code, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", bus.state_code, 0);
        chk("arst_upd", bus.update_req, 0);
        chk("arst_win", bus.win_flag, 0);
        chk("arst_hits", bus.hit_count, 0);
        chk("arst_cnt", bus.bet_count, 0);
        snap = upd_seen;
        tick(); rst = 1'b0;
        repeat (4) tick();
        chk("arst_no_upd", upd_seen, snap);

        do_confirm(); do_confirm();
        pick(6'd20);
        spin_round(0, 1'b1, 3'd1, 16'd10, 16'd10000, 1'b0, 1'b1, 4'd9);
        chk("game_clear", bus.game_clear, 1);
        bet_up_n(1); do_confirm();
        chk("clear_stuck", bus.state_code, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
